// File: rtl/health_meter_if.sv
// Pixel-position, event and display signals exchanged between the HUD and one health meter.
interface health_meter_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        new_frame;
    logic        damage_in;
    logic        heal_in;
    logic [7:0]  hp_out;
    logic [11:0] bcd_out;
    logic        dead_out;
    logic [11:0] pixel_out;

    modport master (
        output hcount_in, vcount_in, new_frame, damage_in, heal_in,
        input  hp_out, bcd_out, dead_out, pixel_out
    );

    modport slave (
        input  hcount_in, vcount_in, new_frame, damage_in, heal_in,
        output hp_out, bcd_out, dead_out, pixel_out
    );
endinterface

// File: rtl/health_meter.sv
// Player health meter: saturating HP with damage/heal edges, flash/dead FSM,
// BCD export and a registered horizontal bar renderer.
module health_meter #(
    parameter int MAX_HP       = 100,
    parameter int DAMAGE_STEP  = 8,
    parameter int HEAL_STEP    = 4,
    parameter int LOW_HP       = 24,
    parameter int PX_PER_HP    = 1,
    parameter int POS_X        = 480,
    parameter int POS_Y        = 720,
    parameter int HEIGHT       = 32,
    parameter int FLASH_FRAMES = 8
) (
    input logic          clk,
    input logic          rst,
    health_meter_if.slave hm
);
    localparam int CW = (FLASH_FRAMES < 2) ? 1 : $clog2(FLASH_FRAMES + 1);
    localparam logic [CW-1:0] FLASH_N = CW'(FLASH_FRAMES);
    localparam logic [7:0]  HP_FULL = 8'(MAX_HP);
    localparam logic [15:0] X0      = 16'(POS_X);
    localparam logic [15:0] X_END   = 16'(POS_X + MAX_HP * PX_PER_HP);
    localparam logic [15:0] Y0      = 16'(POS_Y);
    localparam logic [15:0] Y_END   = 16'(POS_Y + HEIGHT);

    typedef enum logic [1:0] {ALIVE, FLASH, DEAD} state_t;

    state_t        state, state_n;
    logic [7:0]    hp, hp_n;
    logic [CW-1:0] flash_cnt, cnt_n;
    logic [11:0]   bcd;
    logic          dead;
    logic [11:0]   pixel, pixel_n;
    logic          damage_q, heal_q;

    // Shift-add-3 binary to BCD; hundreds fit in 4 bits for any 8-bit value.
    function automatic logic [11:0] to_bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

    wire dmg_ev  = hm.damage_in & ~damage_q;
    wire heal_ev = hm.heal_in & ~heal_q;

    logic [8:0] hp9, heal_sum;
    logic [7:0] hp_dmg, hp_heal;
    always_comb begin
        hp9      = {1'b0, hp};
        heal_sum = hp9 + 9'(HEAL_STEP);
        hp_dmg   = (hp9 > 9'(DAMAGE_STEP)) ? 8'(hp9 - 9'(DAMAGE_STEP)) : 8'd0;
        hp_heal  = (heal_sum > 9'(MAX_HP)) ? HP_FULL : heal_sum[7:0];
    end

    // Damage wins over a coincident heal; a hit also overrides a frame tick.
    always_comb begin
        state_n = state;
        hp_n    = hp;
        cnt_n   = flash_cnt;
        case (state)
            ALIVE, FLASH: begin
                if (dmg_ev) begin
                    hp_n = hp_dmg;
                    if (hp_dmg == 8'd0) begin
                        state_n = DEAD;
                        cnt_n   = '0;
                    end else begin
                        state_n = FLASH;
                        cnt_n   = FLASH_N;
                    end
                end else begin
                    if (heal_ev) hp_n = hp_heal;
                    if (state == FLASH && hm.new_frame) begin
                        cnt_n = flash_cnt - 1'b1;
                        if (flash_cnt == CW'(1)) state_n = ALIVE;
                    end
                end
            end
            default: begin
                hp_n  = 8'd0;
                cnt_n = '0;
            end
        endcase
    end

    logic [15:0] hx, vy, fill_end;
    logic [11:0] fill_col;
    always_comb begin
        hx       = {5'd0, hm.hcount_in};
        vy       = {6'd0, hm.vcount_in};
        fill_end = X0 + 16'(hp) * 16'(PX_PER_HP);
        fill_col = ({1'b0, hp} <= 9'(LOW_HP)) ? 12'hF00 : 12'hFF0;
        if (state == FLASH && flash_cnt[0]) fill_col = 12'hFFF;
        pixel_n = 12'h000;
        if (vy >= Y0 && vy < Y_END && hx >= X0 && hx < X_END) begin
            if (state == DEAD || hx >= fill_end) pixel_n = 12'h400;
            else                                 pixel_n = fill_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALIVE;
            hp        <= HP_FULL;
            flash_cnt <= '0;
            bcd       <= to_bcd(HP_FULL);
            dead      <= 1'b0;
            pixel     <= 12'h000;
            damage_q  <= 1'b0;
            heal_q    <= 1'b0;
        end else begin
            state     <= state_n;
            hp        <= hp_n;
            flash_cnt <= cnt_n;
            bcd       <= to_bcd(hp);
            dead      <= (state_n == DEAD);
            pixel     <= pixel_n;
            damage_q  <= hm.damage_in;
            heal_q    <= hm.heal_in;
        end
    end

    assign hm.hp_out    = hp;
    assign hm.bcd_out   = bcd;
    assign hm.dead_out  = dead;
    assign hm.pixel_out = pixel;
endmodule

// File: tb/tb_health_meter.sv
// Bench for health_meter: directed scenarios plus random stimulus against an event-level model.
module tb_health_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    health_meter_if hm();

    health_meter dut (.clk(clk), .rst(rst), .hm(hm));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 alive, 1 flashing, 2 dead.
    int m_hp, m_st, m_cnt, m_bcd, m_pix, m_dead;
    bit m_dprev, m_hprev;

    function automatic int bcd_of(int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int pix_of(int h, int v);
        int fill;
        if (v < 720 || v >= 752 || h < 480 || h >= 580) return 0;
        if (m_st == 2 || h >= 480 + m_hp) return 'h400;
        fill = (m_hp <= 24) ? 'hF00 : 'hFF0;
        if (m_st == 1 && (m_cnt % 2) == 1) fill = 'hFFF;
        return fill;
    endfunction

    task automatic cycle();
        int pix, old_hp;
        bit dev, hev;
        pix    = pix_of(int'(hm.hcount_in), int'(hm.vcount_in));
        old_hp = m_hp;
        @(posedge clk);
        #1;
        if (rst) begin
            m_hp = 100; m_st = 0; m_cnt = 0; m_bcd = 'h100; m_pix = 0; m_dead = 0;
            m_dprev = 0; m_hprev = 0;
        end else begin
            dev = hm.damage_in && !m_dprev;
            hev = hm.heal_in && !m_hprev;
            if (m_st != 2) begin
                if (dev) begin
                    m_hp = (m_hp > 8) ? m_hp - 8 : 0;
                    if (m_hp == 0) begin m_st = 2; m_cnt = 0; end
                    else begin m_st = 1; m_cnt = 8; end
                end else begin
                    if (hev) m_hp = (m_hp + 4 > 100) ? 100 : m_hp + 4;
                    if (m_st == 1 && hm.new_frame) begin
                        m_cnt--;
                        if (m_cnt == 0) m_st = 0;
                    end
                end
            end
            m_dprev = hm.damage_in;
            m_hprev = hm.heal_in;
            m_bcd   = bcd_of(old_hp);
            m_pix   = pix;
            m_dead  = (m_st == 2);
        end
    endtask

    task automatic hit();
        hm.damage_in = 1'b1; cycle();
        hm.damage_in = 1'b0; cycle();
    endtask

    task automatic heal();
        hm.heal_in = 1'b1; cycle();
        hm.heal_in = 1'b0; cycle();
    endtask

    task automatic frame();
        hm.new_frame = 1'b1; cycle();
        hm.new_frame = 1'b0; cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; cycle();
    endtask

    task automatic test_reset();
        hm.hcount_in = 11'd480; hm.vcount_in = 10'd720;
        rst = 1'b1; cycle(); cycle();
        checks++; if (hm.hp_out !== 8'd100) begin errors++; $display("FAIL reset_hp got %0d want 100", hm.hp_out); end
        checks++; if (hm.bcd_out !== 12'h100) begin errors++; $display("FAIL reset_bcd got %h want 100", hm.bcd_out); end
        checks++; if (hm.dead_out !== 1'b0) begin errors++; $display("FAIL reset_dead got %b want 0", hm.dead_out); end
        checks++; if (hm.pixel_out !== 12'h000) begin errors++; $display("FAIL reset_pixel got %h want 000", hm.pixel_out); end
        rst = 1'b0; cycle();
        checks++; if (hm.pixel_out !== 12'hFF0) begin errors++; $display("FAIL first_pixel got %h want FF0", hm.pixel_out); end
    endtask

    task automatic test_held_damage();
        hm.damage_in = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        hm.damage_in = 1'b0; cycle();
        checks++; if (hm.hp_out !== 8'd92) begin errors++; $display("FAIL held_damage got %0d want 92", hm.hp_out); end
        checks++; if (hm.bcd_out !== 12'h092) begin errors++; $display("FAIL held_bcd got %h want 092", hm.bcd_out); end
        for (int i = 0; i < 7; i++) frame();
        checks++; if (hm.pixel_out !== 12'hFFF) begin errors++; $display("FAIL flash_frame7 got %h want FFF", hm.pixel_out); end
        frame(); frame();
        checks++; if (hm.pixel_out !== 12'hFF0) begin errors++; $display("FAIL flash_done got %h want FF0", hm.pixel_out); end
    endtask

    task automatic test_simultaneous();
        int exp_hp [5] = '{88, 92, 96, 100, 100};
        hm.damage_in = 1'b1; hm.heal_in = 1'b1; cycle();
        hm.damage_in = 1'b0; hm.heal_in = 1'b0; cycle();
        checks++; if (hm.hp_out !== 8'd84) begin errors++; $display("FAIL dmg_and_heal got %0d want 84", hm.hp_out); end
        for (int i = 0; i < 5; i++) begin
            heal();
            checks++;
            if (int'(hm.hp_out) !== exp_hp[i]) begin
                errors++; $display("FAIL heal_%0d got %0d want %0d", i, hm.hp_out, exp_hp[i]);
            end
        end
    endtask

    task automatic test_death();
        do_reset();
        for (int i = 0; i < 12; i++) hit();
        checks++; if (hm.hp_out !== 8'd4) begin errors++; $display("FAIL twelve_hits got %0d want 4", hm.hp_out); end
        checks++; if (hm.bcd_out !== 12'h004) begin errors++; $display("FAIL bcd_4 got %h want 004", hm.bcd_out); end
        checks++; if (hm.dead_out !== 1'b0) begin errors++; $display("FAIL alive_at_4 got %b want 0", hm.dead_out); end
        hm.damage_in = 1'b1; cycle();
        checks++; if (hm.dead_out !== 1'b1 || hm.hp_out !== 8'd0) begin
            errors++; $display("FAIL death got dead=%b hp=%0d want dead=1 hp=0", hm.dead_out, hm.hp_out);
        end
        hm.damage_in = 1'b0; cycle();
        heal(); heal();
        checks++; if (hm.hp_out !== 8'd0) begin errors++; $display("FAIL dead_heal got %0d want 0", hm.hp_out); end
        checks++; if (hm.pixel_out !== 12'h400) begin errors++; $display("FAIL dead_pixel got %h want 400", hm.pixel_out); end
    endtask

    task automatic test_pixel();
        int xs [9] = '{479, 480, 531, 532, 579, 580, 500, 500, 500};
        int ys [9] = '{720, 720, 720, 720, 751, 720, 719, 751, 752};
        int ps [9] = '{'h000, 'hFF0, 'hFF0, 'h400, 'h400, 'h000, 'h000, 'hFF0, 'h000};
        do_reset();
        for (int i = 0; i < 6; i++) hit();
        for (int i = 0; i < 8; i++) frame();
        checks++; if (hm.hp_out !== 8'd52) begin errors++; $display("FAIL hp_52 got %0d want 52", hm.hp_out); end
        for (int i = 0; i < 9; i++) begin
            hm.hcount_in = 11'(xs[i]); hm.vcount_in = 10'(ys[i]); cycle();
            checks++;
            if (int'(hm.pixel_out) !== ps[i]) begin
                errors++; $display("FAIL pixel_%0d_%0d got %h want %h", xs[i], ys[i], hm.pixel_out, ps[i]);
            end
        end
    endtask

    task automatic test_low_health();
        hm.hcount_in = 11'd480; hm.vcount_in = 10'd720;
        for (int i = 0; i < 4; i++) hit();
        heal();
        checks++; if (hm.hp_out !== 8'd24) begin errors++; $display("FAIL hp_24 got %0d want 24", hm.hp_out); end
        checks++; if (hm.pixel_out !== 12'hF00) begin errors++; $display("FAIL low_fill got %h want F00", hm.pixel_out); end
        frame();
        checks++; if (hm.pixel_out !== 12'hFFF) begin errors++; $display("FAIL low_flash_odd got %h want FFF", hm.pixel_out); end
        frame();
        checks++; if (hm.pixel_out !== 12'hF00) begin errors++; $display("FAIL low_flash_even got %h want F00", hm.pixel_out); end
    endtask

    task automatic test_reset_mid();
        hm.damage_in = 1'b1; cycle();
        rst = 1'b1; hm.damage_in = 1'b0; cycle();
        checks++; if (hm.hp_out !== 8'd100 || hm.pixel_out !== 12'h000) begin
            errors++; $display("FAIL rst_flash got hp=%0d pix=%h want 100/000", hm.hp_out, hm.pixel_out);
        end
        rst = 1'b0; frame();
        checks++; if (hm.pixel_out !== 12'hFF0) begin errors++; $display("FAIL rst_flash_alive got %h want FF0", hm.pixel_out); end
        for (int i = 0; i < 13; i++) hit();
        rst = 1'b1; cycle();
        checks++; if (hm.hp_out !== 8'd100 || hm.dead_out !== 1'b0 || hm.pixel_out !== 12'h000) begin
            errors++; $display("FAIL rst_dead got hp=%0d dead=%b pix=%h want 100/0/000", hm.hp_out, hm.dead_out, hm.pixel_out);
        end
        rst = 1'b0; cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            hm.damage_in = ($urandom_range(0, 4) == 0);
            hm.heal_in   = ($urandom_range(0, 2) == 0);
            hm.new_frame = ($urandom_range(0, 5) == 0);
            hm.hcount_in = 11'($urandom_range(470, 590));
            hm.vcount_in = 10'($urandom_range(714, 758));
            cycle();
            checks++;
            if (int'(hm.hp_out) !== m_hp || int'(hm.bcd_out) !== m_bcd ||
                int'(hm.dead_out) !== m_dead || int'(hm.pixel_out) !== m_pix) begin
                errors++;
                $display("FAIL random_%0d got hp=%0d bcd=%h dead=%b pix=%h want hp=%0d bcd=%h dead=%0d pix=%h",
                         i, hm.hp_out, hm.bcd_out, hm.dead_out, hm.pixel_out, m_hp, m_bcd, m_dead, m_pix);
            end
        end
        rst = 1'b0; hm.damage_in = 1'b0; hm.heal_in = 1'b0; hm.new_frame = 1'b0;
    endtask

    initial begin
        hm.hcount_in = '0; hm.vcount_in = '0;
        hm.new_frame = 1'b0; hm.damage_in = 1'b0; hm.heal_in = 1'b0;
        m_hp = 100; m_st = 0; m_cnt = 0; m_bcd = 'h100; m_pix = 0; m_dead = 0;
        m_dprev = 0; m_hprev = 0;
        test_reset();
        test_held_damage();
        test_simultaneous();
        test_death();
        test_pixel();
        test_low_health();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
